// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer between execute stage and one data-memory port.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
package mem_access_pkg;
    localparam int MEM_TYPE_LEN = 3;
    localparam logic [MEM_TYPE_LEN-1:0] MEM_B  = 3'b000;
    localparam logic [MEM_TYPE_LEN-1:0] MEM_H  = 3'b001;
    localparam logic [MEM_TYPE_LEN-1:0] MEM_W  = 3'b010;
    localparam logic [MEM_TYPE_LEN-1:0] MEM_BU = 3'b100;
    localparam logic [MEM_TYPE_LEN-1:0] MEM_HU = 3'b101;
endpackage

module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_store,
    input  logic [MEM_TYPE_LEN-1:0] i_req_type,
    input  logic [XLEN-1:0]         i_req_addr,
    input  logic [XLEN-1:0]         i_req_wdata,
    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic [XLEN-1:0]         o_resp_rdata,
    output logic [XLEN-1:0]         o_resp_addr,
    output logic [MEM_TYPE_LEN-1:0] o_resp_type,
    output logic                    o_resp_misaligned,
    output logic                    o_resp_buserr,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [3:0]              o_mem_be,
    output logic [XLEN-1:0]         o_mem_addr,
    output logic [XLEN-1:0]         o_mem_wdata,
    input  logic                    i_mem_ack,
    input  logic [XLEN-1:0]         i_mem_rdata
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]              r_state;
    logic                    r_store;
    logic [MEM_TYPE_LEN-1:0] r_type;
    logic [XLEN-1:0]         r_addr;
    logic [XLEN-1:0]         r_wdata;
    logic [XLEN-1:0]         r_rdata;
    logic                    r_mis;
    logic                    w_bus;
    logic                    w_resp;
    logic                    w_mis;
    logic                    w_to;
    logic                    w_in_b;
    logic                    w_in_h;
    logic                    w_b;
    logic                    w_h;
    logic [3:0]              w_be;
    logic [XLEN-1:0]         w_wdata;

    assign w_in_b = i_req_type == MEM_B || i_req_type == MEM_BU;
    assign w_in_h = i_req_type == MEM_H || i_req_type == MEM_HU;
    assign w_b    = r_type == MEM_B || r_type == MEM_BU;
    assign w_h    = r_type == MEM_H || r_type == MEM_HU;
    // unknown type codes are handled as full words
    assign w_mis   = w_in_b ? 1'b0 : w_in_h ? i_req_addr[0] : |i_req_addr[1:0];
    assign w_be    = w_b ? 4'b0001 << r_addr[1:0] : w_h ? 4'b0011 << r_addr[1:0] : 4'b1111;
    assign w_wdata = w_b ? {4{r_wdata[7:0]}} : w_h ? {2{r_wdata[15:0]}} : r_wdata;
    assign w_bus   = r_state == S_BUS;
    assign w_resp  = r_state == S_RESP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_store <= 1'b0;
            r_type  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_mis   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_req_valid) begin
                    r_store <= i_req_store;
                    r_type  <= i_req_type;
                    r_addr  <= i_req_addr;
                    r_wdata <= i_req_wdata;
                    r_rdata <= '0;
                    r_mis   <= w_mis;
                    r_state <= w_mis ? S_RESP : S_BUS;
                end
                S_BUS: if (i_mem_ack) begin
                    r_rdata <= r_store ? '0 : i_mem_rdata;
                    r_state <= S_RESP;
                end else if (w_to) begin
                    r_state <= S_RESP;
                end
                S_RESP: if (i_resp_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] r_cnt;
    logic          r_buserr;
    // fires on the last permitted BUS cycle; an ack in that cycle still wins
    assign w_to = r_cnt == LIMIT;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_buserr <= 1'b0;
        end else begin
            r_cnt <= (w_bus && !i_mem_ack) ? r_cnt + 1'b1 : '0;
            if (r_state == S_IDLE) r_buserr <= 1'b0;
            else if (w_bus && !i_mem_ack && w_to) r_buserr <= 1'b1;
        end
    end
    assign o_resp_buserr = w_resp & r_buserr;
`else
    assign w_to          = 1'b0;
    assign o_resp_buserr = 1'b0;
`endif

    assign o_req_ready       = r_state == S_IDLE;
    assign o_resp_valid      = w_resp;
    assign o_resp_rdata      = r_rdata;
    assign o_resp_addr       = r_addr;
    assign o_resp_type       = r_type;
    assign o_resp_misaligned = w_resp & r_mis;
    assign o_mem_req         = w_bus;
    assign o_mem_we          = w_bus & r_store;
    assign o_mem_be          = w_bus ? w_be : 4'b0000;
    assign o_mem_addr        = w_bus ? {r_addr[XLEN-1:2], 2'b00} : '0;
    assign o_mem_wdata       = w_bus ? w_wdata : '0;
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store sequencer between the execute stage and the single data-memory port.
- Accepts one access request at a time and checks alignment. Generates byte enables and lane-replicated store data, then holds the memory request until acknowledged.
- Returns the raw read word, plus its address and type, so the downstream load formatter can shift and extend it.
- Stalls the pipeline through a ready/valid handshake on both sides.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- MEM_TYPE_LEN, from shared constants header, width of access-type code; encodings MEM_B/MEM_H/MEM_W/MEM_BU/MEM_HU come from the same header.
- TIMEOUT_CYCLES, 255, bus watchdog limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  controller can accept an access
- req_store  in  1  1=store, 0=load
- req_type  in  MEM_TYPE_LEN  access size/sign code
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-aligned
- resp_valid  out  1  access complete
- resp_ready  in  1  consumer takes response
- resp_rdata  out  XLEN  raw memory word (loads); 0 for stores/faults
- resp_addr  out  XLEN  latched byte address
- resp_type  out  MEM_TYPE_LEN  latched type
- resp_misaligned  out  1  alignment fault, no bus cycle issued
- resp_buserr  out  1  watchdog fault (see Optional Feature)
- mem_req  out  1  memory request
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables
- mem_addr  out  XLEN  word address, {req_addr[XLEN-1:2],2'b00}
- mem_wdata  out  XLEN  lane-replicated store data
- mem_ack  in  1  memory completes the request this cycle
- mem_rdata  in  XLEN  read word, valid when mem_ack=1

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE.
  - All outputs 0 except req_ready=1.
  - Latched addr/type/data are cleared to 0.
  - Reset during BUS drops mem_req in the same instant; no response is produced.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid&req_ready and latch store/type/addr/wdata.
  - Misaligned access (H/HU with addr[0]=1, or W with addr[1:0]!=0): go to RESP with resp_misaligned=1; no mem_req is ever asserted.
  - Aligned access: go to BUS.
- BUS:
  - req_ready=0, mem_req=1, mem_we=latched store flag.
  - mem_addr/mem_be/mem_wdata are stable until ack.
  - mem_ack is sampled each rising edge while mem_req=1; ack is legal on the first BUS cycle.
  - On ack, load: capture mem_rdata into resp_rdata. Store: resp_rdata=0. Then go to RESP; mem_req deasserts the next cycle.
  - mem_ack outside BUS is ignored.
- RESP:
  - resp_valid=1; resp_* are held stable until resp_ready=1.
  - On resp_ready, go to IDLE; resp_valid and fault flags clear next cycle.
  - Minimum aligned latency: accept edge -> BUS (1 cycle) -> RESP, i.e. resp_valid 2 cycles after accept with zero-wait ack. Misaligned latency: 1 cycle.
  - No new request is accepted while in BUS or RESP (one outstanding access).
- Byte enables, off = addr[1:0]:
  - B/BU: 4'b0001<<off.
  - H/HU: 4'b0011<<off.
  - W: 4'b1111.
  - Any other code: treated as W.
- Store data lane replication:
  - B/BU: {4{wdata[7:0]}}.
  - H/HU: {2{wdata[15:0]}}.
  - W: wdata.
  - Stores with BU/HU codes behave identically to B/H.
- mem_be and mem_wdata are also driven for loads; mem_wdata is don't-care for loads but deterministic (same rule).

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: drop mem_req, go to RESP with resp_buserr=1 and resp_rdata=0.
  - An ack arriving in the same cycle the limit is hit wins (normal completion).
- Undefined: no counter; BUS waits indefinitely; resp_buserr is tied to 0.

Test Plan:
- Load W at 0x100, mem_ack on first BUS cycle with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=4'b1111, mem_we=0; resp_valid 2 cycles after accept with resp_rdata=0xDEADBEEF, resp_addr=0x100.
- Store B at 0x203 with wdata=0x000000A5, ack after 3 wait cycles -> mem_addr=0x200, mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_req held 4 cycles, resp_rdata=0.
- Load H at 0x102 -> mem_be=4'b1100. Load H at 0x101 -> no mem_req; resp_valid next cycle with resp_misaligned=1.
- Back-to-back requests with resp_ready=0 for 5 cycles -> response held stable; req_ready stays 0 until resp_ready, then the second request is accepted from IDLE.
- rst_n pulsed low mid-BUS -> mem_req drops immediately; after release req_ready=1, resp_valid=0, no stale response.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> mem_req high exactly 4 cycles, then resp_buserr=1, resp_rdata=0.
